// File: rtl/mux_rr_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: sizes, FSM state type
// and one-hot to index encoding.
package mux_rr_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (oh[n]) idx = SEL_W'(n);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_sched_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4)
// and returns the first requester found.
module rr_pick4
  import mux_rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any_valid
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx       = ptr;
    any_valid = 1'b0;
    cand      = '0;
    // Walk downward from offset 4 (ptr itself) so the nearest hit wins last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx       = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning the select lines of a 4:1 mux; bounds each
// grant to MAX_HOLD cycles while another requester is waiting.
module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DW-1:0]      i0,
  input  logic [DW-1:0]      i1,
  input  logic [DW-1:0]      i2,
  input  logic [DW-1:0]      i3,
  output logic               s1,
  output logic               s0,
  output logic [NUM_REQ-1:0] gnt,
  output logic [DW-1:0]      y,
  output logic               y_valid
);

  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   last_ptr, last_nxt;
  logic [SEL_W-1:0]   sel;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0]   win_idx;
  logic               win_any;

  // Current owner is searched last, so it only wins again when nobody else asks.
  rr_pick4 u_pick (
    .req       (req),
    .ptr       (last_ptr),
    .idx       (win_idx),
    .any_valid (win_any)
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last_ptr;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = GRANT;
          gnt_nxt   = NUM_REQ'(1) << win_idx;
          last_nxt  = win_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (!req[last_ptr] || hold_cnt == HOLD_LAST) begin
          if (win_any) begin
            gnt_nxt  = NUM_REQ'(1) << win_idx;
            last_nxt = win_idx;
            hold_nxt = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            hold_nxt  = '0;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last_ptr <= SEL_W'(NUM_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_ptr <= last_nxt;
      hold_cnt <= hold_nxt;
      if (gnt_nxt != '0) sel <= onehot_to_idx(gnt_nxt);
    end
  end

  assign s1      = sel[1];
  assign s0      = sel[0];
  assign y_valid = |gnt;

  // Existing 4:1 mux replicated per data bit, qualified by y_valid.
  for (genvar b = 0; b < DW; b++) begin : g_mux
    assign y[b] = y_valid & (s1 ? (s0 ? i3[b] : i2[b]) : (s0 ? i1[b] : i0[b]));
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Randomized and directed bench for mux_rr_sched against a tenure-based
// round-robin reference model.
module tb_mux_rr_sched;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] i0, i1, i2, i3;
  logic          s1, s0, y_valid;
  logic [3:0]    gnt;
  logic [DW-1:0] y;

  int errors = 0;
  int checks = 0;

  int owner;
  int last;
  int tenure;
  int msel;
  int wait_cnt [4];
  int max_wait;

  mux_rr_sched #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .i0      (i0),
    .i1      (i1),
    .i2      (i2),
    .i3      (i3),
    .s1      (s1),
    .s0      (s0),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Owner keeps the mux for at most MAX_HOLD visible cycles; then the next
  // requester after the last-granted index takes it (possibly the owner again).
  task automatic model(input logic r, input logic [3:0] rq);
    int pick;
    if (r) begin
      owner = -1; last = 3; tenure = 0; msel = 0;
      return;
    end
    if (owner >= 0 && rq[owner] && tenure < MAX_HOLD) begin
      tenure++;
    end else begin
      pick = -1;
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && rq[(last + k) % 4]) pick = (last + k) % 4;
      if (pick < 0) begin
        owner = -1;
      end else begin
        owner = pick; last = pick; msel = pick; tenure = 1;
      end
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int s);
    case (s)
      0: return i0;
      1: return i1;
      2: return i2;
      default: return i3;
    endcase
  endfunction

  task automatic step(input logic r, input logic [3:0] rq);
    logic [3:0]    eg;
    logic [DW-1:0] ey;
    rst = r;
    req = rq;
    @(posedge clk);
    model(r, rq);
    #1;
    eg = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    ey = (owner < 0) ? '0 : data_of(msel);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel", 32'({s1, s0}), 32'(msel));
    chk("y_valid", 32'(y_valid), 32'(owner >= 0));
    chk("y", 32'(y), 32'(ey));
    for (int n = 0; n < 4; n++) begin
      if (!r && rq[n] && !gnt[n]) wait_cnt[n]++;
      else wait_cnt[n] = 0;
      if (wait_cnt[n] > max_wait) max_wait = wait_cnt[n];
    end
  endtask

  task automatic rand_data();
    i0 = DW'($urandom); i1 = DW'($urandom); i2 = DW'($urandom); i3 = DW'($urandom);
  endtask

  initial begin
    logic [3:0] rq;
    owner = -1; last = 3; tenure = 0; msel = 0; max_wait = 0;
    for (int n = 0; n < 4; n++) wait_cnt[n] = 0;
    rst = 1'b1; req = 4'b1111;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;

    // Reset held with all requests asserted
    rand_data();
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'({s1, s0}), 32'h0);

    // Single request on input 2, then release
    i0 = '0; i1 = '0; i2 = DW'(1); i3 = '0;
    step(1'b0, 4'b0100);
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_y", 32'(y), 32'h1);
    step(1'b0, 4'b0000);
    chk("t2_drop_gnt", 32'(gnt), 32'h0);
    chk("t2_drop_sel", 32'({s1, s0}), 32'h2);

    // Full contention rotation (from reset so requester 0 goes first)
    step(1'b1, 4'b0000);
    for (int c = 0; c < 17; c++) begin
      rand_data();
      step(1'b0, 4'b1111);
      chk("t3_rot", 32'(gnt), 32'(4'b0001 << ((c / MAX_HOLD) % 4)));
    end

    // Hand-off without a bubble
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b1000);
    chk("t4_gnt", 32'(gnt), 32'h8);
    chk("t4_vld", 32'(y_valid), 32'h1);

    // Lone requester is never interrupted
    for (int c = 0; c < 12; c++) begin
      rand_data();
      step(1'b0, 4'b0010);
      chk("t5_lone", 32'(gnt), 32'h2);
    end

    // Reset mid-grant, then contention restarts at requester 0
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    chk("t6_rst_y", 32'(y), 32'h0);
    step(1'b0, 4'b1111);
    chk("t6_first", 32'(gnt), 32'h1);

    // Randomized traffic with sticky requests to exercise fairness
    rq = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      rand_data();
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 7) == 0) rq[n] = ~rq[n];
      if ($urandom_range(0, 199) == 0) step(1'b1, rq);
      else step(1'b0, rq);
    end
    chk("starve_bound", 32'(max_wait <= 3 * MAX_HOLD + 1), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
